sign_ext_accum: RTL and testbench

- Downstream consumer of narrow port-driven values (1–2 bit signed/unsigned generator outputs, pass-through stages).
- Extends each accepted sample to OUT_W bits: sign extension when the sample is tagged signed, zero extension otherwise.
- Accumulates COUNT extended samples modulo 2^OUT_W and emits the group sum over a valid/ready handshake.
- Serves as a sequential check that extension semantics survive synthesis.

---
 rtl/sign_ext_pkg.sv | 45 ++++
 rtl/sign_ext_unit.sv | 25 ++
 rtl/sign_ext_accum.sv | 143 ++++++++++++++
 tb/tb_sign_ext_accum.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sign_ext_pkg.sv
// -----------------------------------------------------------------------------
// sign_ext_pkg
//   Shared definitions for the sign-extending group accumulator.
//   - state_t   : controller states (ACC collects samples, HOLD presents a sum)
//   - cnt_width : width of the per-group sample counter, at least one bit
//   - ext_fn    : sign or zero extension of an IN_W-bit value; the result is
//                 returned in a fixed EXT_MAX_W container so a single function
//                 serves every IN_W/OUT_W pairing (callers truncate to OUT_W)
// -----------------------------------------------------------------------------
package sign_ext_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Widest extension result supported by ext_fn.
  localparam int EXT_MAX_W = 64;

  function automatic int cnt_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Bits below in_w are copied; every bit above is the fill bit, which is the
  // sample's MSB for a signed sample and zero otherwise. With in_w equal to
  // the caller's output width the fill bits are all truncated away, so the
  // sample passes through unchanged.
  function automatic logic [EXT_MAX_W-1:0] ext_fn(
    input logic [EXT_MAX_W-1:0] data,
    input logic                 is_signed,
    input int                   in_w
  );
    logic [EXT_MAX_W-1:0] res;
    logic                 msb;
    msb = 1'b0;
    for (int i = 0; i < EXT_MAX_W; i++) begin
      if (i == in_w - 1) msb = data[i];
    end
    for (int i = 0; i < EXT_MAX_W; i++) begin
      res[i] = (i < in_w) ? data[i] : (is_signed & msb);
    end
    return res;
  endfunction

endpackage

// File: rtl/sign_ext_unit.sv
// -----------------------------------------------------------------------------
// sign_ext_unit
//   Purely combinational extender: widens an IN_W-bit sample to OUT_W bits,
//   sign-extending when in_signed is set and zero-extending otherwise.
//   OUT_W must not exceed sign_ext_pkg::EXT_MAX_W.
//
//   Ports
//     in_data   [IN_W-1:0]   sample
//     in_signed              1 = sign-extend, 0 = zero-extend
//     ext       [OUT_W-1:0]  extended sample
// -----------------------------------------------------------------------------
module sign_ext_unit
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  output logic [OUT_W-1:0] ext
);

  assign ext = OUT_W'(ext_fn(EXT_MAX_W'(in_data), in_signed, IN_W));

endmodule

// File: rtl/sign_ext_accum.sv
// -----------------------------------------------------------------------------
// sign_ext_accum
//   Extends each accepted sample to OUT_W bits (sign or zero extension chosen
//   per sample), sums COUNT samples modulo 2^OUT_W and offers the group sum
//   on a valid/ready output. While a sum waits to be taken no new sample is
//   accepted, except in the cycle the sum is taken, where the incoming sample
//   starts the next group.
//
//   Parameters
//     IN_W   sample width (>= 1)
//     OUT_W  extended / accumulator width (>= IN_W, <= 64)
//     COUNT  samples per group (>= 1)
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous, active-high reset
//     clear      synchronous discard of the partial group (wins over accept)
//     in_data    sample
//     in_signed  1 = sign-extend in_data, 0 = zero-extend
//     in_valid   sample present
//     in_ready   sample is accepted this cycle when in_valid is high
//     out_data   group sum, two's complement, wraps modulo 2^OUT_W
//     out_valid  out_data holds a completed sum
//     out_ready  downstream takes out_data
// -----------------------------------------------------------------------------
module sign_ext_accum
  import sign_ext_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 4,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_signed,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int             CNT_W    = cnt_width(COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state, state_nxt;
  logic [OUT_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [OUT_W-1:0]   out_data_nxt;
  logic [OUT_W-1:0]   ext;
  logic [OUT_W-1:0]   sum;
  logic               accept;

  sign_ext_unit #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .in_data   (in_data),
    .in_signed (in_signed),
    .ext       (ext)
  );

  // HOLD only lets a sample in during the cycle the pending sum is taken.
  // Both terms come from registered state or out_ready, never from in_valid.
  assign in_ready  = (state == ACC) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  // Natural OUT_W-bit truncation gives the required modulo-2^OUT_W wrap.
  assign sum = acc + ext;

  // NOTE: every next-state variable is given its hold value before the case
  // statement, so no path through the block leaves one unassigned and no
  // latch can be inferred.
  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    out_data_nxt = out_data;

    unique case (state)
      ACC: begin
        if (clear) begin
          // clear outranks accept: a sample offered now is dropped even
          // though in_ready reads 1.
          acc_nxt = '0;
          cnt_nxt = '0;
        end else if (accept) begin
          if (cnt == CNT_LAST) begin
            out_data_nxt = sum;
            acc_nxt      = '0;
            cnt_nxt      = '0;
            state_nxt    = HOLD;
          end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + CNT_ONE;
          end
        end
      end

      HOLD: begin
        // acc and cnt are already zero here: they are cleared on entry and
        // nothing accumulates while a sum is pending.
        if (out_ready) begin
          state_nxt = ACC;
          if (accept && !clear) begin
            if (COUNT == 1) begin
              // A single-sample group completes in the release cycle, so
              // the sum is replaced and out_valid never drops.
              out_data_nxt = ext;
              state_nxt    = HOLD;
            end else begin
              acc_nxt = ext;
              cnt_nxt = CNT_ONE;
            end
          end
        end
      end

      default: state_nxt = ACC;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      cnt      <= cnt_nxt;
      out_data <= out_data_nxt;
    end
  end

endmodule

// File: tb/tb_sign_ext_accum.sv
// -----------------------------------------------------------------------------
// tb_sign_ext_accum
//   Three instances (COUNT = 4, 6, 1; IN_W = 2, OUT_W = 4) share the sample
//   stream; each has its own out_ready. A group-sum model pushes expected sums
//   into one queue per instance when a group completes; a monitor on the
//   falling edge compares out_valid, in_ready and out_data against the queue
//   heads and pops on each transfer.
// -----------------------------------------------------------------------------
module tb_sign_ext_accum;

  localparam int IN_W  = 2;
  localparam int OUT_W = 4;
  localparam int NI    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic [IN_W-1:0]  in_data;
  logic             in_signed;
  logic             in_valid;
  logic             in_ready  [NI];
  logic [OUT_W-1:0] out_data  [NI];
  logic             out_valid [NI];
  logic             out_ready [NI];

  int n_checks = 0;
  int n_errors = 0;

  int grp_n   [NI];
  int grp_sum [NI];
  int exp_q   [NI][$];
  bit aux_rand;

  always #5 clk = ~clk;

  sign_ext_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]));

  sign_ext_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .COUNT(6)) dut6 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]));

  sign_ext_accum #(.IN_W(IN_W), .OUT_W(OUT_W), .COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_data(in_data), .in_signed(in_signed),
    .in_valid(in_valid), .in_ready(in_ready[2]), .out_data(out_data[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]));

  function automatic int count_of(input int k);
    case (k)
      0:       return 4;
      1:       return 6;
      default: return 1;
    endcase
  endfunction

  // Numeric value of a sample: two's complement when signed, plain otherwise.
  function automatic int sample_val(input logic [IN_W-1:0] d, input logic s);
    int v;
    v = int'(d);
    if (s && v >= (1 << (IN_W - 1))) v = v - (1 << IN_W);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic flush_model();
    for (int k = 0; k < NI; k++) begin
      grp_n[k]   = 0;
      grp_sum[k] = 0;
      exp_q[k].delete();
    end
  endtask

  task automatic set_in(input logic v, input logic [IN_W-1:0] d, input logic s,
                        input logic c, input logic r0);
    in_valid     = v;
    in_data      = d;
    in_signed    = s;
    clear        = c;
    out_ready[0] = r0;
    for (int k = 1; k < NI; k++)
      out_ready[k] = aux_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // Applies the current inputs for one clock edge and updates the group model.
  // A sum is pending while its queue is non-empty; a sample gets in when
  // nothing is pending or the pending sum is being taken this cycle.
  task automatic commit();
    bit done [NI];
    int done_val [NI];
    bit rdy;
    for (int k = 0; k < NI; k++) begin
      done[k]     = 1'b0;
      done_val[k] = 0;
      rdy = (exp_q[k].size() == 0) || out_ready[k];
      if (clear) begin
        grp_n[k]   = 0;
        grp_sum[k] = 0;
      end else if (in_valid && rdy) begin
        grp_sum[k] = grp_sum[k] + sample_val(in_data, in_signed);
        grp_n[k]   = grp_n[k] + 1;
        if (grp_n[k] == count_of(k)) begin
          done[k]     = 1'b1;
          done_val[k] = grp_sum[k] & ((1 << OUT_W) - 1);
          grp_n[k]    = 0;
          grp_sum[k]  = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++)
      if (done[k]) exp_q[k].push_back(done_val[k]);
  endtask

  task automatic step(input logic v, input logic [IN_W-1:0] d, input logic s,
                      input logic c, input logic r0);
    set_in(v, d, s, c, r0);
    commit();
  endtask

  // Called just after a rising edge; asserts rst between edges and checks
  // that out_valid falls without waiting for a clock.
  task automatic async_reset();
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
    rst      = 1'b1;
    #1;
    for (int k = 0; k < NI; k++)
      check($sformatf("async_rst_out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare on the falling edge, pop on each transfer.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int k = 0; k < NI; k++) begin
        bit exp_v;
        exp_v = (exp_q[k].size() != 0);
        check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_v));
        check($sformatf("in_ready[%0d]", k), 32'(in_ready[k]),
              32'(!exp_v || out_ready[k]));
        if (exp_v) begin
          check($sformatf("out_data[%0d]", k), 32'(out_data[k]), 32'(exp_q[k][0]));
          if (out_ready[k]) void'(exp_q[k].pop_front());
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    aux_rand = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0, 1'b1);
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset_out_valid[%0d]", k), 32'(out_valid[k]), 32'd0);
      check($sformatf("reset_out_data[%0d]", k), 32'(out_data[k]), 32'd0);
      check($sformatf("reset_in_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
    end

    // Four signed -1 samples -> -4, visible right after the 4th accept.
    repeat (4) step(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
    check("neg4_valid", 32'(out_valid[0]), 32'd1);
    check("neg4_data", 32'(out_data[0]), 32'b1100);

    // 1 (signed) + 3 + 3 + 3 (unsigned) = 10; first sample enters on release.
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    check("mixed_data", 32'(out_data[0]), 32'b1010);

    // 1 - 1 - 1 - 1 = -2.
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    repeat (3) step(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
    check("signed_data", 32'(out_data[0]), 32'b1110);

    // Backpressure: group of four +1 held for five cycles.
    repeat (3) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    step(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      check("bp_valid", 32'(out_valid[0]), 32'd1);
      check("bp_data", 32'(out_data[0]), 32'b0100);
      check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    set_in(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    #1;
    check("release_in_ready", 32'(in_ready[0]), 32'd1);
    commit();
    repeat (3) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check("after_release_data", 32'(out_data[0]), 32'b0100);
    check("after_release_valid", 32'(out_valid[0]), 32'd1);

    // Reset while a sum is held, then reset mid-group.
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid[0]), 32'd1);
    async_reset();
    repeat (2) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    async_reset();
    repeat (4) step(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", 32'(out_data[0]), 32'b0100);

    // COUNT=6: six unsigned 3s -> 18 mod 16 = 2. COUNT=1: signed 2'b10 -> -2.
    async_reset();
    repeat (6) step(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
    check("count6_valid", 32'(out_valid[1]), 32'd1);
    check("count6_data", 32'(out_data[1]), 32'b0010);
    step(1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
    check("count1_valid", 32'(out_valid[2]), 32'd1);
    check("count1_data", 32'(out_data[2]), 32'b1110);

    // clear drops the partial group and the sample offered with it.
    async_reset();
    repeat (2) step(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
    set_in(1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    #1;
    check("clear_in_ready", 32'(in_ready[0]), 32'd1);
    commit();
    repeat (4) step(1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
    check("after_clear_data", 32'(out_data[0]), 32'b0100);

    // Randomized traffic with random backpressure, clears and resets.
    aux_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        step(($urandom_range(0, 3) != 0), IN_W'($urandom), 1'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7));
      end
    end

    // Drain: every expected sum must have been delivered.
    aux_rand = 1'b0;
    repeat (4) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NI; k++)
      check($sformatf("drained[%0d]", k), 32'(exp_q[k].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
